// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types for the pipeline hazard sequencer (states, control bundle).
// Revision : 1.0
// ============================================================================
package hazard_ctrl_pkg;

    localparam int REG_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_HALT  = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE   = 7'b000_0000;
    // Hold PC and IF/ID, send a bubble into EX (load-use and fetch miss)
    localparam hz_ctrl_t CTRL_BUBBLE = 7'b110_0100;
    // Freeze everything upstream of WB, bubble into WB (data miss and halt)
    localparam hz_ctrl_t CTRL_FREEZE = 7'b110_1011;

    function automatic logic is_miss(input hz_state_e st);
        return (st == ST_IMISS) || (st == ST_DMISS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use comparator between the ID sources and EX load.
// Revision : 1.0
// ============================================================================
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    // Register 0 is compared like any other register.
    assign load_use = ex_memrd & ((id_rs_used & (id_rs == ex_rd)) |
                                  (id_rt_used & (id_rt == ex_rd)));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline (miss FSM, halt, watchdog).
//            Optional HAZARD_PERF_EN adds saturating lu/br/miss event counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_br_taken,
    input  logic             id_hlt,
    input  logic             wb_hlt,
    input  logic             imem_miss,
    input  logic             imem_ready,
    input  logic             dmem_miss,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             tmo_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      lu_cnt,
    output logic [15:0]      br_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    localparam logic [TMO_W-1:0] WD_MAX = '1;

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    hz_state_e        w_run_nxt;
    hz_ctrl_t         w_run_ctrl;
    hz_ctrl_t         w_ctrl;
    hz_ctrl_t         w_out;
    logic             w_load_use;
    logic             w_dm_req;
    logic             w_im_req;
    logic [TMO_W-1:0] r_wd;
    logic             r_tmo;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .ex_memrd   (ex_memrd),
        .ex_rd      (ex_rd),
        .load_use   (w_load_use)
    );

    // A ready cycle behaves as RUN but must not re-trigger the miss it just closed.
    assign w_dm_req = dmem_miss & (r_state != ST_DMISS);
    assign w_im_req = imem_miss & (r_state != ST_IMISS);

    always_comb begin
        w_run_ctrl = CTRL_NONE;
        w_run_nxt  = ST_RUN;
        if (w_dm_req) begin
            w_run_ctrl = CTRL_FREEZE;
            w_run_nxt  = ST_DMISS;
        end else if (w_im_req) begin
            w_run_ctrl = CTRL_BUBBLE;
            w_run_nxt  = ST_IMISS;
        end else if (w_load_use) begin
            w_run_ctrl = CTRL_BUBBLE;
        end else begin
            w_run_ctrl.if_id_flush = id_br_taken;
            w_run_ctrl.pc_stall    = id_hlt;
        end
    end

    always_comb begin
        w_ctrl      = CTRL_NONE;
        w_state_nxt = r_state;
        if (wb_hlt || (r_state == ST_HALT)) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = w_run_nxt;
                end
                ST_DMISS: begin
                    if (dmem_ready) begin
                        w_ctrl      = w_run_ctrl;
                        w_state_nxt = w_run_nxt;
                    end else begin
                        w_ctrl = CTRL_FREEZE;
                    end
                end
                ST_IMISS: begin
                    if (dmem_miss || imem_ready) begin
                        w_ctrl      = w_run_ctrl;
                        w_state_nxt = w_run_nxt;
                    end else begin
                        w_ctrl = CTRL_BUBBLE;
                    end
                end
                default: begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_HALT;
                end
            endcase
        end
    end

    // Stall wins over flush on the same register; everything quiet in reset.
    always_comb begin
        w_out = CTRL_NONE;
        if (rst_n) begin
            w_out             = w_ctrl;
            w_out.if_id_flush = w_ctrl.if_id_flush & ~w_ctrl.if_id_stall;
            w_out.id_ex_flush = w_ctrl.id_ex_flush & ~w_ctrl.id_ex_stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_wd    <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (is_miss(r_state) && is_miss(w_state_nxt)) begin
                r_wd <= (r_wd == WD_MAX) ? r_wd : r_wd + TMO_W'(1);
            end else begin
                r_wd <= '0;
            end
            if (is_miss(r_state) && (r_wd >= WD_MAX - TMO_W'(1))) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign pc_stall     = w_out.pc_stall;
    assign if_id_stall  = w_out.if_id_stall;
    assign if_id_flush  = w_out.if_id_flush;
    assign id_ex_stall  = w_out.id_ex_stall;
    assign id_ex_flush  = w_out.id_ex_flush;
    assign ex_mem_stall = w_out.ex_mem_stall;
    assign mem_wb_flush = w_out.mem_wb_flush;
    assign halted       = (r_state == ST_HALT);
    assign tmo_err      = r_tmo;

`ifdef HAZARD_PERF_EN
    logic        w_run_path;
    logic        w_lu_evt;
    logic        w_br_evt;
    logic [15:0] r_lu_cnt;
    logic [15:0] r_br_cnt;
    logic [15:0] r_miss_cnt;

    assign w_run_path = ~wb_hlt & ((r_state == ST_RUN) ||
                                   ((r_state == ST_DMISS) && dmem_ready) ||
                                   ((r_state == ST_IMISS) && (dmem_miss || imem_ready)));
    assign w_lu_evt   = w_run_path & ~w_dm_req & ~w_im_req & w_load_use;
    assign w_br_evt   = w_run_path & ~w_dm_req & ~w_im_req & ~w_load_use & id_br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_cnt   <= '0;
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lu_evt && (r_lu_cnt != 16'hFFFF)) r_lu_cnt <= r_lu_cnt + 16'd1;
            if (w_br_evt && (r_br_cnt != 16'hFFFF)) r_br_cnt <= r_br_cnt + 16'd1;
            if (is_miss(r_state) && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign lu_cnt   = r_lu_cnt;
    assign br_cnt   = r_br_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: vector table, corner sequences, random vs model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_W  = 4;
    localparam int TMO_W  = 4;
    localparam int WD_LIM = (1 << TMO_W) - 1;

    // Output bundle order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] E_NONE = 7'b000_0000;
    localparam logic [6:0] E_LU   = 7'b110_0100;
    localparam logic [6:0] E_IM   = 7'b110_0100;
    localparam logic [6:0] E_BR   = 7'b001_0000;
    localparam logic [6:0] E_PC   = 7'b100_0000;
    localparam logic [6:0] E_DM   = 7'b110_1011;
    localparam logic [6:0] E_HALT = 7'b110_1011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_rs_used, id_rt_used, ex_memrd, id_br_taken, id_hlt, wb_hlt;
    logic             imem_miss, imem_ready, dmem_miss, dmem_ready;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic             ex_mem_stall, mem_wb_flush, halted, tmo_err;
    logic [6:0]       act;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.REG_W(REG_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_memrd(ex_memrd), .ex_rd(ex_rd), .id_br_taken(id_br_taken), .id_hlt(id_hlt),
        .wb_hlt(wb_hlt), .imem_miss(imem_miss), .imem_ready(imem_ready),
        .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .halted(halted), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    // Reference model: which wait the pipeline is in, plus length of the current miss run
    bit         m_halt, m_dwait, m_iwait, m_tmo;
    bit         n_halt, n_dwait, n_iwait;
    int         m_run;
    logic [6:0] m_exp;

    task automatic model_reset();
        m_halt = 0; m_dwait = 0; m_iwait = 0; m_tmo = 0; m_run = 0;
    endtask

    task automatic model_eval();
        bit lu, d_act, i_act;
        lu    = ex_memrd && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        d_act = m_dwait ? !dmem_ready : dmem_miss;
        i_act = m_iwait ? !imem_ready : imem_miss;
        n_halt = m_halt; n_dwait = 0; n_iwait = 0;
        if (m_halt || wb_hlt) begin
            m_exp = E_HALT; n_halt = 1;
        end else if (d_act) begin
            m_exp = E_DM; n_dwait = 1;
        end else if (i_act) begin
            m_exp = E_IM; n_iwait = 1;
        end else if (lu) begin
            m_exp = E_LU;
        end else begin
            m_exp = (id_br_taken ? E_BR : E_NONE) | (id_hlt ? E_PC : E_NONE);
        end
    endtask

    task automatic model_commit();
        if (m_dwait || m_iwait) begin
            m_run++;
            if (m_run >= WD_LIM) m_tmo = 1;
        end else begin
            m_run = 0;
        end
        m_halt = n_halt; m_dwait = n_dwait; m_iwait = n_iwait;
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rd = '0; id_rs_used = 0; id_rt_used = 0; ex_memrd = 0;
        id_br_taken = 0; id_hlt = 0; wb_hlt = 0;
        imem_miss = 0; imem_ready = 0; dmem_miss = 0; dmem_ready = 0;
    endtask

    // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick(input string name, input bit chk, input logic [6:0] exp);
        @(negedge clk);
        model_eval();
        check({name, "/model"}, act, m_exp);
        if (chk) check(name, act, exp);
        check({name, "/status"}, {halted, tmo_err}, {m_halt, m_tmo});
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset(input string name);
        idle();
        rst_n = 0;
        #2;
        check({name, "/rst_out"}, act, E_NONE);
        check({name, "/rst_status"}, {halted, tmo_err}, 2'b00);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0] rs, rt;
        logic       rs_u, rt_u, memrd;
        logic [3:0] rd;
        logic       br, hlt;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [10];
    int   halt_cyc;
    int   rdy_div;

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        do_reset("por");

        //          rs    rt    rsu  rtu  memrd rd    br   hlt  exp
        tbl[0] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, E_NONE};
        tbl[1] = '{4'h3, 4'h5, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, E_LU};
        tbl[2] = '{4'h1, 4'h7, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, E_LU};
        tbl[3] = '{4'h3, 4'h7, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, E_NONE};
        tbl[4] = '{4'h3, 4'h3, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, E_NONE};
        tbl[5] = '{4'h0, 4'h9, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, E_LU};
        tbl[6] = '{4'h2, 4'h4, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0, E_BR};
        tbl[7] = '{4'h3, 4'h4, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, E_LU};
        tbl[8] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, E_PC};
        tbl[9] = '{4'hF, 4'hE, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, E_LU};
        for (int i = 0; i < 10; i++) begin
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_rs_used = tbl[i].rs_u; id_rt_used = tbl[i].rt_u;
            ex_memrd = tbl[i].memrd; ex_rd = tbl[i].rd; id_br_taken = tbl[i].br; id_hlt = tbl[i].hlt;
            tick($sformatf("vec%0d", i), 1, tbl[i].exp);
        end
        idle();
        tick("lu_after", 1, E_NONE);

        // Data miss for five cycles, then ready
        dmem_miss = 1;
        for (int i = 0; i < 5; i++) tick($sformatf("dmiss%0d", i), 1, E_DM);
        dmem_miss = 0; dmem_ready = 1;
        tick("dmiss_ready", 1, E_NONE);
        idle();
        tick("dmiss_run", 1, E_NONE);

        // Both misses together: data first, then instruction
        imem_miss = 1; dmem_miss = 1;
        tick("both0", 1, E_DM);
        tick("both1", 1, E_DM);
        dmem_miss = 0; dmem_ready = 1; id_br_taken = 1;
        tick("both_dready", 1, E_IM);
        dmem_ready = 0;
        tick("imiss_hold", 1, E_IM);
        imem_miss = 0; imem_ready = 1; id_br_taken = 0;
        tick("imiss_ready", 1, E_NONE);
        idle();
        tick("imiss_run", 1, E_NONE);

        // Watchdog with no ready, then async reset in the middle of a miss
        dmem_miss = 1;
        tick("wd_enter", 1, E_DM);
        for (int i = 0; i < WD_LIM; i++) tick("wd_wait", 1, E_DM);
        check("tmo_set", {8'd0, tmo_err}, 9'd1);
        dmem_miss = 0; dmem_ready = 1;
        tick("wd_ready", 1, E_NONE);
        idle();
        tick("wd_after", 1, E_NONE);
        check("tmo_sticky", {8'd0, tmo_err}, 9'd1);
        dmem_miss = 1;
        tick("rst_miss0", 1, E_DM);
        tick("rst_miss1", 1, E_DM);
        do_reset("midmiss");
        tick("post_rst", 1, E_NONE);
        id_rs = 4'h3; id_rs_used = 1; ex_memrd = 1; ex_rd = 4'h3;
        tick("post_rst_lu", 1, E_LU);
        idle();

        // HLT fetch stop, retire three cycles later, then frozen
        id_hlt = 1;
        tick("hlt_id", 1, E_PC);
        idle();
        tick("hlt_gap1", 1, E_NONE);
        tick("hlt_gap2", 1, E_NONE);
        wb_hlt = 1;
        tick("hlt_wb", 1, E_HALT);
        for (int i = 0; i < 8; i++) begin
            wb_hlt = 0;
            id_br_taken = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
            imem_miss = 1'($urandom_range(0, 1)); imem_ready = 1'($urandom_range(0, 1));
            dmem_miss = 1'($urandom_range(0, 1)); id_hlt = 1'($urandom_range(0, 1));
            tick("halted_hold", 1, E_HALT);
        end
        check("halted_flag", {8'd0, halted}, 9'd1);
        do_reset("halt_exit");

        // Random traffic against the model
        halt_cyc = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy_div     = ((c / 500) % 2 == 1) ? 19 : 2;
            id_rs       = 4'($urandom_range(0, 3));
            id_rt       = 4'($urandom_range(0, 3));
            ex_rd       = 4'($urandom_range(0, 3));
            id_rs_used  = 1'($urandom_range(0, 1));
            id_rt_used  = 1'($urandom_range(0, 1));
            ex_memrd    = 1'($urandom_range(0, 1));
            id_br_taken = 1'($urandom_range(0, 1));
            id_hlt      = ($urandom_range(0, 9) == 0);
            wb_hlt      = ($urandom_range(0, 399) == 0);
            imem_miss   = ($urandom_range(0, 7) == 0);
            imem_ready  = ($urandom_range(0, rdy_div) == 0);
            dmem_miss   = ($urandom_range(0, 9) == 0);
            dmem_ready  = ($urandom_range(0, rdy_div) == 0);
            tick("rand", 0, E_NONE);
            if (m_halt) begin
                halt_cyc++;
                if (halt_cyc > 4) begin
                    do_reset("rand_rst");
                    halt_cyc = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
